alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared combinational ALU. Two requesters (the main execute stage and an auxiliary unit such as an address/loop helper) each present a complete ALU operation (opcode, two operands, 3-bit immediate). The block grants the ALU to one requester at a time, holds the operation stable for a full execute cycle, registers the result and branch flag, and returns them with a one-cycle acknowledge. It sits between the requesters and the ALU ports; the ALU itself stays purely combinational.

## Interface
Parameters:
- DW, 8, operand/result width (ALU data width)
- OPW, 4, opcode width
- IMW, 3, immediate width

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  request from port 0 / port 1; held high until that port's ack
- op0, op1  in  OPW each  ALU opcode of the request
- a0, a1  in  DW each  operand A
- b0, b1  in  DW each  operand B
- im0, im1  in  IMW each  immediate
- ack0, ack1  out  1 each  one-cycle pulse: result for that port is valid
- gnt  out  2  one-hot current owner (00 when idle)
- rsp_data  out  DW  registered ALU result (valid when any ack is high)
- rsp_branch  out  1  registered ALU branch flag (valid with ack)
- busy  out  1  high in EXEC and RESP
- alu_op  out  OPW  to ALU OP
- alu_a, alu_b  out  DW each  to ALU InputA/InputB
- alu_im  out  IMW  to ALU Im
- alu_out  in  DW  from ALU Out
- alu_branch  in  1  from ALU Branch

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port not served last (last pointer). On grant: latch op/a/b/im of winner into operand registers, set gnt one-hot, update last, go EXEC.
- EXEC: alu_* driven from operand registers (stable all cycle). At end of cycle capture alu_out -> rsp_data, alu_branch -> rsp_branch; go RESP.
- RESP: ack of granted port = 1, rsp_data/rsp_branch valid, gnt still set. Next state IDLE; gnt cleared on exit.
- Requests are sampled only in IDLE; req level in EXEC/RESP is ignored. An accepted request is committed: dropping req before ack does not cancel it and ack is still issued.
- Input operands may change after grant without effect (latched).
- rsp_data/rsp_branch hold their last value until the next EXEC capture.
- alu_op/alu_a/alu_b/alu_im hold the last operation's values in IDLE and RESP (no toggling when idle).
- Reset: state IDLE, gnt=00, ack0=ack1=0, busy=0, rsp_data=0, rsp_branch=0, alu_*=0, last=port 1 (so port 0 wins the first tie). Reset mid-operation aborts; no ack for the aborted request. A req still high after reset is re-arbitrated normally.

## Timing
- Cycle 0: IDLE samples req -> grant at edge.
- Cycle 1: EXEC, ALU evaluates.
- Cycle 2: RESP, ack high exactly one cycle.
- Cycle 3: IDLE; earliest next grant is sampled here, so throughput is 1 op per 3 cycles.
- Requester protocol: deassert req on the edge where ack is seen. A req still high in cycle 3 is treated as a new request.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1…; each port waits at most 6 cycles from req to ack.
- No combinational path from req/op/a/b/im to any output; all outputs are registered.

## Test plan
- Single op: req0 with op=ADD, a0=8'h05, b0=8'h03 at cycle 0 -> gnt=01 cycles 1-2, ack0 at cycle 2, rsp_data=8'h08, ack1 never high.
- Tie after reset: req0 and req1 both rise in the same cycle -> port 0 served first (ack0 at cycle 2), port 1 granted at cycle 3, ack1 at cycle 5.
- Continuous contention: both reqs held, each re-raised after its own ack, for 12 ops -> acks strictly alternate, no port waits more than 6 cycles.
- Operand change after grant: a0 changes 0x05->0xFF in cycle 1 -> rsp_data still 0x08; alu_a stable at 0x05 through EXEC.
- Branch pass-through: BNZL with a1=8'h01 -> rsp_branch=1 with ack1; a1=8'h00 -> rsp_branch=0.
- Reset in EXEC: assert Reset during cycle 1 -> no ack, all outputs return to reset values next cycle; req0 still high afterwards -> re-granted and acked 2 cycles after Reset drops.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer that shares one combinational ALU between two requesters.
// Each granted operation runs IDLE -> EXEC -> RESP, with a registered result and a one-cycle ack.
module alu_arbiter #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 4,
  parameter int unsigned IMW = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [OPW-1:0] op0,
  input  logic [OPW-1:0] op1,
  input  logic [DW-1:0]  a0,
  input  logic [DW-1:0]  a1,
  input  logic [DW-1:0]  b0,
  input  logic [DW-1:0]  b1,
  input  logic [IMW-1:0] im0,
  input  logic [IMW-1:0] im1,
  output logic           ack0,
  output logic           ack1,
  output logic [1:0]     gnt,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_branch,
  output logic           busy,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [IMW-1:0] alu_im,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_branch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [IMW-1:0] im;
  } alu_cmd_t;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_branch_q, rsp_branch_d;
  alu_cmd_t        cmd_q, cmd_d;
  logic            last_q, last_d;

  alu_cmd_t        cmd0_c, cmd1_c;
  logic            any_req_c;
  logic            pick1_c;

  // Winner selection: a lone request wins; on a tie the port not served last wins.
  always_comb begin
    cmd0_c    = '{op: op0, a: a0, b: b0, im: im0};
    cmd1_c    = '{op: op1, a: a1, b: b1, im: im1};
    any_req_c = req0 | req1;
    pick1_c   = req1 & (~req0 | ~last_q);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ack_d        = 2'b00;
    busy_d       = busy_q;
    rsp_data_d   = rsp_data_q;
    rsp_branch_d = rsp_branch_q;
    cmd_d        = cmd_q;
    last_d       = last_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          cmd_d   = pick1_c ? cmd1_c : cmd0_c;
          gnt_d   = pick1_c ? 2'b10 : 2'b01;
          last_d  = pick1_c;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d   = alu_out;
        rsp_branch_d = alu_branch;
        ack_d        = gnt_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // last_q resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      ack_q        <= 2'b00;
      busy_q       <= 1'b0;
      rsp_data_q   <= '0;
      rsp_branch_q <= 1'b0;
      cmd_q        <= '0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      rsp_data_q   <= rsp_data_d;
      rsp_branch_q <= rsp_branch_d;
      cmd_q        <= cmd_d;
      last_q       <= last_d;
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_branch = rsp_branch_q;
  assign alu_op     = cmd_q.op;
  assign alu_a      = cmd_q.a;
  assign alu_b      = cmd_q.b;
  assign alu_im     = cmd_q.im;

endmodule
